// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants, fetch state encoding and instruction field
//               slices for the 15-bit CPU front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int ADDR_W  = 2;
  localparam int INSTR_W = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Instruction field boundaries, shared with decode
  localparam int c_opcode_hi = 14;
  localparam int c_opcode_lo = 13;
  localparam int c_fa_hi     = 12;
  localparam int c_fa_lo     = 11;
  localparam int c_fb_hi     = 10;
  localparam int c_fb_lo     = 9;
  localparam int c_we_bit    = 8;
  localparam int c_rd_hi     = 7;
  localparam int c_rd_lo     = 6;
  localparam int c_rs_hi     = 5;
  localparam int c_rs_lo     = 4;
  localparam int c_imm_hi    = 3;
  localparam int c_imm_lo    = 0;

  function automatic logic [1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[c_opcode_hi:c_opcode_lo];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : ROM address/data path and the valid/ready issue channel
//               between the fetch sequencer and decode.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 2,
  parameter int INSTR_W = 15
);

  logic [ADDR_W-1:0]  instr_addr;
  logic [INSTR_W-1:0] instr;
  logic               issue_valid;
  logic [INSTR_W-1:0] issue_instr;
  logic [ADDR_W-1:0]  issue_pc;
  logic               issue_ready;

  // Fetch side
  modport master (
    output instr_addr,
    input  instr,
    output issue_valid,
    output issue_instr,
    output issue_pc,
    input  issue_ready
  );

  // ROM + decode side
  modport slave (
    input  instr_addr,
    output instr,
    input  issue_valid,
    input  issue_instr,
    input  issue_pc,
    output issue_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_issue_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_issue_reg
// Description : Single-entry valid/ready pipeline register with flush.
//               in_ready depends only on the stored valid and the downstream
//               ready, so out_valid never sees a combinational ready path.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer_issue_reg #(
  parameter int DATA_W = 17
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              flush,
  input  wire logic              in_valid,
  output logic                   in_ready,
  input  wire logic [DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  wire logic              out_ready,
  output logic [DATA_W-1:0]      out_data
);

  import cpu_pkg::*;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  assign in_ready  = !r_valid || out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  // Flush beats load; a consumed entry with nothing behind it empties the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch controller. Owns the PC, drives the ROM
//               address, registers returned words into the issue stage and
//               sequences start/halt/redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int CNT_W   = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  input  wire logic              halt_req,
  input  wire logic              redirect_valid,
  input  wire logic [ADDR_W-1:0] redirect_addr,
  fetch_sequencer_if.master      bus,
  output logic                   running,
  output logic                   halted,
  output logic                   wrapped,
  output logic [CNT_W-1:0]       issued_cnt
);

  import cpu_pkg::*;

  localparam int c_data_w = INSTR_W + ADDR_W;

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [ADDR_W-1:0]     r_pc;
  logic                  r_wrapped;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_load_req;
  logic                  w_load_fire;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_issue_valid;
  logic [c_data_w-1:0]   w_issue_data;

  // Redirect owns the cycle: no load, register flushed
  assign w_load_req  = (r_state == RUN) && !halt_req && !redirect_valid;
  assign w_load_fire = w_load_req && w_in_ready;
  assign w_accept    = w_issue_valid && bus.issue_ready;

  assign bus.instr_addr  = r_pc;
  assign bus.issue_valid = w_issue_valid;
  assign bus.issue_instr = w_issue_data[c_data_w-1:ADDR_W];
  assign bus.issue_pc    = w_issue_data[ADDR_W-1:0];

  assign running    = (r_state == RUN);
  assign halted     = (r_state == HALT);
  assign wrapped    = r_wrapped;
  assign issued_cnt = r_cnt;

  fetch_sequencer_issue_reg #(
    .DATA_W (c_data_w)
  ) issue_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .in_valid  (w_load_req),
    .in_ready  (w_in_ready),
    .in_data   ({bus.instr, r_pc}),
    .out_valid (w_issue_valid),
    .out_ready (bus.issue_ready),
    .out_data  (w_issue_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: halt waits for the pending issue to drain (redirect drains it)
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (start) w_state_next = RUN;
      RUN:  if (halt_req && (redirect_valid || !w_issue_valid || bus.issue_ready))
              w_state_next = HALT;
      HALT: if (start && !halt_req) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  // PC: redirect in any state, otherwise advance on each load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_pc <= '0;
    else if (redirect_valid) r_pc <= redirect_addr;
    else if (w_load_fire)    r_pc <= r_pc + 1'b1;
  end

  // Wrap pulse only for a sequential advance out of the last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wrapped <= 1'b0;
    else        r_wrapped <= w_load_fire && (r_pc == {ADDR_W{1'b1}});
  end

  // Saturating count of completed handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_cnt <= '0;
    else if (w_accept && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer with a
//               scoreboard of expected issued {instr, pc} pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  import cpu_pkg::*;

  localparam int AW = 2;
  localparam int IW = 15;
  localparam int CW = 8;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          halt_req = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          running;
  logic          halted;
  logic          wrapped;
  logic [CW-1:0] issued_cnt;

  logic [IW-1:0] rom [4];
  exp_t          sb [$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_fail = 0;

  fetch_sequencer_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  assign bus.instr = rom[bus.instr_addr];

  fetch_sequencer #(
    .ADDR_W  (AW),
    .INSTR_W (IW),
    .CNT_W   (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (bus),
    .running        (running),
    .halted         (halted),
    .wrapped        (wrapped),
    .issued_cnt     (issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int a);
    sb.push_back(exp_t'{rom[a], AW'(a)});
  endtask

  // Each handshake about to complete on the next edge must match the head
  always @(negedge clk) begin
    if (rst_n && bus.issue_valid && bus.issue_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("hs_instr", 32'(bus.issue_instr), 32'(mon_e.instr));
        check("hs_pc",    32'(bus.issue_pc),    32'(mon_e.pc));
      end
    end
  end

  initial begin
    rom[0] = 15'h1A2B;
    rom[1] = 15'h2C3D;
    rom[2] = 15'h4E5F;
    rom[3] = 15'h7071;
    bus.issue_ready = 1'b0;

    // Reset state
    #2;
    check("rst_instr_addr", 32'(bus.instr_addr), 0);
    check("rst_valid",      32'(bus.issue_valid), 0);
    check("rst_instr",      32'(bus.issue_instr), 0);
    check("rst_pc",         32'(bus.issue_pc), 0);
    check("rst_running",    32'(running), 0);
    check("rst_halted",     32'(halted), 0);
    check("rst_wrapped",    32'(wrapped), 0);
    check("rst_cnt",        32'(issued_cnt), 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("idle_running", 32'(running), 0);

    // Streaming through all words with wrap
    start = 1'b1;
    bus.issue_ready = 1'b1;
    step(1);
    start = 1'b0;
    check("t1_running", 32'(running), 1);
    check("t1_valid0",  32'(bus.issue_valid), 0);
    push(0); push(1); push(2); push(3); push(0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t1_pc",      32'(bus.issue_pc), 32'(i));
      check("t1_instr",   32'(bus.issue_instr), 32'(rom[i]));
      check("t1_wrapped", 32'(wrapped), 32'(i == 3));
      check("t1_cnt",     32'(issued_cnt), 32'(i));
    end
    step(1);
    check("t1_pc_wrap",  32'(bus.issue_pc), 0);
    check("t1_wrap_off", 32'(wrapped), 0);
    check("t1_cnt4",     32'(issued_cnt), 4);

    // Backpressure at pc 1
    step(1);
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("bp_valid", 32'(bus.issue_valid), 1);
      check("bp_instr", 32'(bus.issue_instr), 32'(rom[1]));
      check("bp_pc",    32'(bus.issue_pc), 1);
      check("bp_addr",  32'(bus.instr_addr), 2);
      check("bp_cnt",   32'(issued_cnt), 5);
    end
    push(1); push(2);
    bus.issue_ready = 1'b1;
    step(1);
    check("bp_rel_instr", 32'(bus.issue_instr), 32'(rom[2]));
    check("bp_rel_pc",    32'(bus.issue_pc), 2);
    check("bp_rel_cnt",   32'(issued_cnt), 6);

    // Redirect to 3 while (W1,1) is being accepted
    push(3); push(0); push(1);
    step(3);
    check("rd_pre_pc", 32'(bus.issue_pc), 1);
    redirect_valid = 1'b1;
    redirect_addr  = 2'd3;
    step(1);
    redirect_valid = 1'b0;
    check("rd_flush",   32'(bus.issue_valid), 0);
    check("rd_cnt",     32'(issued_cnt), 10);
    check("rd_addr",    32'(bus.instr_addr), 3);
    check("rd_nowrap",  32'(wrapped), 0);
    push(3); push(0);
    step(1);
    check("rd_w3_instr", 32'(bus.issue_instr), 32'(rom[3]));
    check("rd_w3_pc",    32'(bus.issue_pc), 3);
    check("rd_w3_wrap",  32'(wrapped), 1);
    step(1);
    check("rd_w0_pc",  32'(bus.issue_pc), 0);
    check("rd_w0_cnt", 32'(issued_cnt), 11);

    // Halt with a pending issue under backpressure
    bus.issue_ready = 1'b0;
    halt_req = 1'b1;
    step(2);
    check("ht_running", 32'(running), 1);
    check("ht_valid",   32'(bus.issue_valid), 1);
    check("ht_pc_held", 32'(bus.issue_pc), 0);
    bus.issue_ready = 1'b1;
    step(1);
    check("ht_halted", 32'(halted), 1);
    check("ht_run0",   32'(running), 0);
    check("ht_valid0", 32'(bus.issue_valid), 0);
    check("ht_cnt",    32'(issued_cnt), 12);
    check("ht_pc",     32'(bus.instr_addr), 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("ht_start_ignored", 32'(halted), 1);
    halt_req = 1'b0;
    start = 1'b1;
    push(1);
    step(1);
    start = 1'b0;
    check("ht_resume_run", 32'(running), 1);
    step(1);
    check("ht_resume_instr", 32'(bus.issue_instr), 32'(rom[1]));
    check("ht_resume_pc",    32'(bus.issue_pc), 1);

    // Redirect to 0 together with halt
    redirect_valid = 1'b1;
    redirect_addr  = 2'd0;
    halt_req = 1'b1;
    step(1);
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    check("rh_halted", 32'(halted), 1);
    check("rh_addr",   32'(bus.instr_addr), 0);
    check("rh_valid",  32'(bus.issue_valid), 0);
    check("rh_nowrap", 32'(wrapped), 0);
    check("rh_cnt",    32'(issued_cnt), 13);

    // Asynchronous reset mid-run with pc=2 and a pending issue
    redirect_valid = 1'b1;
    redirect_addr  = 2'd1;
    step(1);
    redirect_valid = 1'b0;
    check("ar_halt_redirect", 32'(bus.instr_addr), 1);
    bus.issue_ready = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check("ar_pre_valid", 32'(bus.issue_valid), 1);
    check("ar_pre_addr",  32'(bus.instr_addr), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_instr_addr", 32'(bus.instr_addr), 0);
    check("ar_valid",      32'(bus.issue_valid), 0);
    check("ar_instr",      32'(bus.issue_instr), 0);
    check("ar_pc",         32'(bus.issue_pc), 0);
    check("ar_running",    32'(running), 0);
    check("ar_halted",     32'(halted), 0);
    check("ar_cnt",        32'(issued_cnt), 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    check("ar_idle", 32'(running), 0);

    // Counter saturation
    bus.issue_ready = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      push(i % 4);
      step(1);
      if (i == 200) check("sat_mid", 32'(issued_cnt), 200);
      if (i == 280) check("sat_280", 32'(issued_cnt), 255);
    end
    step(1);
    bus.issue_ready = 1'b0;
    check("sat_end", 32'(issued_cnt), 255);
    step(2);
    check("sat_hold", 32'(issued_cnt), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
